// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - round-robin ADC channel sequencer with per-channel sample averaging
// Optional conversion timeout: define ADC_SEQ_TIMEOUT_EN.
module adc_seq_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic        adc_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  input  logic        adc_ready,
  input  logic [13:0] adc_value,
  input  logic        err_clr,
  output logic        adc_start,
  output logic [2:0]  adc_channel_ind,
  output logic [3:0]  adc_counts,
  output logic [13:0] adc_current_0,
  output logic [13:0] adc_current_1,
  output logic        result_valid,
  output logic [2:0]  result_ch,
  output logic [13:0] result_value,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, DONE} state_t;

  localparam int         ACC_W    = 14 + AVG_LOG2;
  localparam logic [3:0] NUM_AVG  = 4'(1 << AVG_LOG2);
  localparam logic [7:0] CH_VALID = 8'((1 << NUM_CH) - 1);

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         ch_q, ch_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [13:0]        cur0_q, cur0_d;
  logic [13:0]        cur1_q, cur1_d;
  logic               rv_q, rv_d;
  logic [2:0]         rch_q, rch_d;
  logic [13:0]        rval_q, rval_d;

  logic [7:0]         mask_eff;
  logic               found;
  logic [2:0]         next_ch;
  logic [2:0]         next_ptr;
  logic [ACC_W-1:0]   acc_sum;
  logic               last_sample;
  logic               timeout_hit;

  assign mask_eff    = ch_mask & CH_VALID;
  assign acc_sum     = acc_q + ACC_W'(adc_value);
  assign last_sample = (cnt_q + 4'd1) == NUM_AVG;
  assign next_ptr    = (next_ch == 3'(NUM_CH - 1)) ? 3'd0 : next_ch + 3'd1;

  // Round-robin search: first masked-in channel at or above ptr_q, wrapping at NUM_CH.
  always_comb begin
    int idx;
    found   = 1'b0;
    next_ch = 3'd0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && mask_eff[3'(idx)]) begin
        found   = 1'b1;
        next_ch = 3'(idx);
      end
    end
  end

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      cur0_q  <= '0;
      cur1_q  <= '0;
      rv_q    <= 1'b0;
      rch_q   <= '0;
      rval_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      cur0_q  <= cur0_d;
      cur1_q  <= cur1_d;
      rv_q    <= rv_d;
      rch_q   <= rch_d;
      rval_q  <= rval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && (mask_eff != 8'd0)) state_d = SELECT;
      SELECT:  state_d = (enable && found) ? START : IDLE;
      START:   state_d = WAIT;
      WAIT: begin
        if (timeout_hit)                    state_d = SELECT;
        else if (adc_ready && last_sample)  state_d = DONE;
        else if (adc_ready)                 state_d = START;
      end
      DONE:    state_d = SELECT;
      default: state_d = IDLE;
    endcase
  end

  // Results are registered on the final sample so they are visible during DONE.
  always_comb begin
    ptr_d  = ptr_q;
    ch_d   = ch_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    cur0_d = cur0_q;
    cur1_d = cur1_q;
    rv_d   = 1'b0;
    rch_d  = rch_q;
    rval_d = rval_q;
    case (state_q)
      SELECT: begin
        cnt_d = '0;
        acc_d = '0;
        if (enable && found) begin
          ch_d  = next_ch;
          ptr_d = next_ptr;
        end
      end
      WAIT: begin
        if (adc_ready) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 4'd1;
          if (last_sample) begin
            rv_d   = 1'b1;
            rch_d  = ch_q;
            rval_d = acc_sum[AVG_LOG2 +: 14];
            if (ch_q == 3'd0) cur0_d = acc_sum[AVG_LOG2 +: 14];
            if (ch_q == 3'd1) cur1_d = acc_sum[AVG_LOG2 +: 14];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    adc_start       = (state_q == START);
    adc_channel_ind = ch_q;
    adc_counts      = cnt_q;
    adc_current_0   = cur0_q;
    adc_current_1   = cur1_q;
    result_valid    = rv_q;
    result_ch       = rch_q;
    result_value    = rval_q;
  end

`ifdef ADC_SEQ_TIMEOUT_EN
  logic [7:0] wcnt_q, wcnt_d;
  logic       terr_q, terr_d;

  // A set in the same cycle as err_clr wins.
  always_comb begin
    timeout_hit = (state_q == WAIT) && !adc_ready && (wcnt_q == 8'(TIMEOUT - 1));
    wcnt_d      = wcnt_q;
    if (state_q == START)                  wcnt_d = '0;
    else if (state_q == WAIT && !adc_ready) wcnt_d = wcnt_q + 8'd1;
    terr_d = timeout_hit | (terr_q & ~err_clr);
  end

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      wcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  logic unused_cfg;
  assign unused_cfg  = err_clr | (TIMEOUT > 255);
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb/tb_adc_seq_ctrl.sv - scoreboard bench for adc_seq_ctrl (NUM_CH=4, AVG_LOG2=2, TIMEOUT=10)
module tb_adc_seq_ctrl;
  logic        adc_clk = 1'b0;
  logic        rst, enable, adc_ready, err_clr;
  logic [7:0]  ch_mask;
  logic [13:0] adc_value;
  logic        adc_start, result_valid, timeout_err;
  logic [2:0]  adc_channel_ind, result_ch;
  logic [3:0]  adc_counts;
  logic [13:0] adc_current_0, adc_current_1, result_value;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0]  ch;
    logic [13:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 adc_clk = ~adc_clk;

  adc_seq_ctrl #(.NUM_CH(4), .AVG_LOG2(2), .TIMEOUT(10)) dut (
    .adc_clk(adc_clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
    .adc_ready(adc_ready), .adc_value(adc_value), .err_clr(err_clr),
    .adc_start(adc_start), .adc_channel_ind(adc_channel_ind), .adc_counts(adc_counts),
    .adc_current_0(adc_current_0), .adc_current_1(adc_current_1),
    .result_valid(result_valid), .result_ch(result_ch), .result_value(result_value),
    .timeout_err(timeout_err)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_start"}, int'(adc_start), 0);
    check({name, "_chan"}, int'(adc_channel_ind), 0);
    check({name, "_counts"}, int'(adc_counts), 0);
    check({name, "_cur0"}, int'(adc_current_0), 0);
    check({name, "_cur1"}, int'(adc_current_1), 0);
    check({name, "_rvalid"}, int'(result_valid), 0);
    check({name, "_rch"}, int'(result_ch), 0);
    check({name, "_rval"}, int'(result_value), 0);
    check({name, "_terr"}, int'(timeout_err), 0);
  endtask

  task automatic pulse(input logic [13:0] v);
    adc_value = v;
    adc_ready = 1'b1;
    @(negedge adc_clk);
    adc_ready = 1'b0;
  endtask

  task automatic wait_start(input int exp_ch);
    int n = 0;
    while (adc_start !== 1'b1 && n < 100) begin
      @(negedge adc_clk);
      n++;
    end
    check("start_seen", int'(adc_start === 1'b1), 1);
    check("start_channel", int'(adc_channel_ind), exp_ch);
  endtask

  // glitch: pulse adc_ready during the START cycle, which must be ignored
  task automatic sample(input int exp_ch, input logic [13:0] v, input int d, input bit glitch);
    int cnt_before;
    wait_start(exp_ch);
    if (glitch) begin
      cnt_before = int'(adc_counts);
      adc_value = 14'd3000;
      adc_ready = 1'b1;
      @(negedge adc_clk);
      adc_ready = 1'b0;
      check("start_ready_ignored", int'(adc_counts), cnt_before);
      repeat (d - 1) @(negedge adc_clk);
    end else begin
      repeat (d) @(negedge adc_clk);
    end
    pulse(v);
  endtask

  task automatic idle_watch(input string name, input int cycles);
    int starts = 0;
    repeat (cycles) begin
      @(negedge adc_clk);
      if (adc_start === 1'b1) starts++;
    end
    check(name, starts, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; ch_mask = 8'h00;
    adc_ready = 1'b0; adc_value = '0; err_clr = 1'b0;

    fork
      forever begin
        @(negedge adc_clk);
        if (result_valid === 1'b1) begin
          check("result_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result_ch", int'(result_ch), int'(e.ch));
            check("result_value", int'(result_value), int'(e.val));
            if (e.ch == 3'd0) check("adc_current_0", int'(adc_current_0), int'(e.val));
            if (e.ch == 3'd1) check("adc_current_1", int'(adc_current_1), int'(e.val));
          end
        end
      end
      begin
        repeat (20000) @(posedge adc_clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge adc_clk);
    check_zero("reset");
    rst = 1'b0;

    enable = 1'b1;
    idle_watch("empty_mask_idle", 8);
    ch_mask = 8'hF0;
    idle_watch("high_mask_bits_ignored", 8);

    // ch0 then ch1, averaged over 4 samples each
    ch_mask = 8'h03;
    exp_q.push_back('{ch: 3'd0, val: 14'd101});
    sample(0, 14'd100, 1, 1'b0);
    sample(0, 14'd101, 2, 1'b0);
    sample(0, 14'd102, 1, 1'b0);
    sample(0, 14'd103, 3, 1'b0);
    check("latency_ch0", int'(result_valid), 1);

    exp_q.push_back('{ch: 3'd1, val: 14'd202});
    sample(1, 14'd200, 1, 1'b0);
    sample(1, 14'd201, 1, 1'b1);
    sample(1, 14'd202, 2, 1'b0);
    sample(1, 14'd207, 1, 1'b0);
    check("latency_ch1", int'(result_valid), 1);
    check("cur0_held", int'(adc_current_0), 101);

    // enable dropped mid-average: channel still completes
    exp_q.push_back('{ch: 3'd0, val: 14'd1001});
    sample(0, 14'd1000, 1, 1'b0);
    enable = 1'b0;
    sample(0, 14'd1001, 1, 1'b0);
    sample(0, 14'd1002, 1, 1'b0);
    sample(0, 14'd1003, 1, 1'b0);
    idle_watch("idle_after_disable", 20);

    // reset in WAIT with two samples taken; pending adc_ready discarded
    enable = 1'b1;
    sample(1, 14'd500, 1, 1'b0);
    sample(1, 14'd501, 1, 1'b0);
    @(negedge adc_clk);
    check("counts_before_rst", int'(adc_counts), 2);
    rst = 1'b1;
    ch_mask = 8'h05;
    adc_value = 14'd9999;
    adc_ready = 1'b1;
    @(negedge adc_clk);
    adc_ready = 1'b0;
    check_zero("mid_wait_reset");
    rst = 1'b0;

    // sparse mask: 0,2,0,2 and restart from channel 0
    exp_q.push_back('{ch: 3'd0, val: 14'd25});
    exp_q.push_back('{ch: 3'd2, val: 14'd16383});
    exp_q.push_back('{ch: 3'd0, val: 14'd6});
    exp_q.push_back('{ch: 3'd2, val: 14'd0});
    sample(0, 14'd10, 1, 1'b0);
    sample(0, 14'd20, 1, 1'b0);
    sample(0, 14'd30, 1, 1'b0);
    sample(0, 14'd41, 1, 1'b0);
    for (int i = 0; i < 4; i++) sample(2, 14'd16383, 1, 1'b0);
    sample(0, 14'd7, 1, 1'b0);
    sample(0, 14'd7, 2, 1'b0);
    sample(0, 14'd7, 1, 1'b0);
    sample(0, 14'd6, 1, 1'b0);
    sample(2, 14'd0, 1, 1'b0);
    enable = 1'b0;
    sample(2, 14'd0, 1, 1'b0);
    sample(2, 14'd0, 1, 1'b0);
    sample(2, 14'd3, 1, 1'b0);
    idle_watch("idle_after_sparse", 20);
    check("cur1_untouched", int'(adc_current_1), 0);

    ch_mask = 8'h03;
    enable = 1'b1;
`ifdef ADC_SEQ_TIMEOUT_EN
    wait_start(0);
    repeat (10) @(negedge adc_clk);
    check("terr_before_timeout", int'(timeout_err), 0);
    @(negedge adc_clk);
    check("terr_after_timeout", int'(timeout_err), 1);
    @(negedge adc_clk);
    check("timeout_next_start", int'(adc_start), 1);
    check("timeout_next_chan", int'(adc_channel_ind), 1);
    enable = 1'b0;
    exp_q.push_back('{ch: 3'd1, val: 14'd8});
    @(negedge adc_clk);
    pulse(14'd8);
    for (int i = 0; i < 3; i++) sample(1, 14'd8, 1, 1'b0);
    idle_watch("idle_after_timeout", 10);
    check("terr_sticky", int'(timeout_err), 1);
    err_clr = 1'b1;
    @(negedge adc_clk);
    err_clr = 1'b0;
    check("terr_cleared", int'(timeout_err), 0);
`else
    wait_start(0);
    err_clr = 1'b1;
    idle_watch("no_timeout_restart", 30);
    check("terr_constant", int'(timeout_err), 0);
    err_clr = 1'b0;
    enable = 1'b0;
    exp_q.push_back('{ch: 3'd0, val: 14'd4});
    pulse(14'd4);
    for (int i = 0; i < 3; i++) sample(0, 14'd4, 1, 1'b0);
    idle_watch("idle_after_long_wait", 10);
`endif

    repeat (5) @(negedge adc_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
